// File: rtl/frontend_stream_arbiter.sv
// Merges command responses, time tags and per-block event words into one 128-bit
// stream: fixed priority cmd > tag > events, round-robin among event blocks.
module frontend_stream_arbiter #(
   parameter int NBLOCKS = 4,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [127:0]             cmd_data,
   input  logic                     tt_valid,
   output logic                     tt_ready,
   input  logic [127:0]             tt_data,
   output logic                     tt_stall,
   input  logic [NBLOCKS-1:0]       ev_valid,
   output logic [NBLOCKS-1:0]       ev_ready,
   input  logic [128*NBLOCKS-1:0]   ev_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [127:0]             out_data,
   output logic [CNT_W-1:0]         period_events,
   output logic                     period_events_valid
);

   localparam int RR_W = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1;

   logic [RR_W-1:0]    rr;
   logic [RR_W-1:0]    ev_idx;
   logic [RR_W-1:0]    rr_after_ev;
   logic               ev_found;
   logic               load;
   logic               grant_cmd;
   logic               grant_tt;
   logic               grant_ev;
   logic [NBLOCKS-1:0] ev_sel;
   logic [127:0]       win_data;
   logic [CNT_W-1:0]   ev_cnt;

   // First valid block at or after rr, wrapping modulo NBLOCKS.
   always_comb begin : rr_search
      logic [RR_W:0] cand;
      cand     = '0;
      ev_found = 1'b0;
      ev_idx   = rr;
      for (int j = 0; j < NBLOCKS; j++) begin
         cand = {1'b0, rr} + (RR_W+1)'(j);
         if (cand >= (RR_W+1)'(NBLOCKS)) begin
            cand = cand - (RR_W+1)'(NBLOCKS);
         end
         if (!ev_found && ev_valid[cand[RR_W-1:0]]) begin
            ev_found = 1'b1;
            ev_idx   = cand[RR_W-1:0];
         end
      end
   end

   always_comb begin
      rr_after_ev = (ev_idx == RR_W'(NBLOCKS - 1)) ? '0 : ev_idx + 1'b1;
   end

   always_comb begin
      load      = ~out_valid | out_ready;
      grant_cmd = ~rst & load & cmd_valid;
      grant_tt  = ~rst & load & ~cmd_valid & tt_valid;
      grant_ev  = ~rst & load & ~cmd_valid & ~tt_valid & ev_found;
   end

   always_comb begin
      ev_sel = '0;
      for (int i = 0; i < NBLOCKS; i++) begin
         ev_sel[i] = grant_ev & (ev_idx == RR_W'(i));
      end
   end

   always_comb begin
      cmd_ready = grant_cmd;
      tt_ready  = grant_tt;
      ev_ready  = ev_sel;
      // Holding the counter while a command is pending keeps tags in order behind it.
      tt_stall  = rst | cmd_valid;
   end

   always_comb begin
      if (grant_cmd) begin
         win_data = cmd_data;
      end else if (grant_tt) begin
         win_data = tt_data;
      end else begin
         win_data = ev_data[128*ev_idx +: 128];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (grant_cmd | grant_tt | grant_ev) begin
         out_valid <= 1'b1;
         out_data  <= win_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr <= '0;
      end else if (grant_ev) begin
         rr <= rr_after_ev;
      end
   end

   // A tag closes the rate-monitor period; tag and event never share a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ev_cnt              <= '0;
         period_events       <= '0;
         period_events_valid <= 1'b0;
      end else begin
         period_events_valid <= grant_tt;
         if (grant_tt) begin
            period_events <= ev_cnt;
            ev_cnt        <= '0;
         end else if (grant_ev && (ev_cnt != {CNT_W{1'b1}})) begin
            ev_cnt <= ev_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frontend_stream_arbiter.sv
// Bench for frontend_stream_arbiter: vector table of inputs and expected grants,
// with a scoreboard queue holding the word expected in the output register.
module tb_frontend_stream_arbiter;

   localparam int NB = 4;

   logic                clk;
   logic                rst;
   logic                cmd_valid;
   logic                cmd_ready;
   logic [127:0]        cmd_data;
   logic                tt_valid;
   logic                tt_ready;
   logic [127:0]        tt_data;
   logic                tt_stall;
   logic [NB-1:0]       ev_valid;
   logic [NB-1:0]       ev_ready;
   logic [128*NB-1:0]   ev_data;
   logic                out_valid;
   logic                out_ready;
   logic [127:0]        out_data;
   logic [15:0]         period_events;
   logic                period_events_valid;

   frontend_stream_arbiter #(.NBLOCKS(NB), .CNT_W(16)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .cmd_valid           (cmd_valid),
      .cmd_ready           (cmd_ready),
      .cmd_data            (cmd_data),
      .tt_valid            (tt_valid),
      .tt_ready            (tt_ready),
      .tt_data             (tt_data),
      .tt_stall            (tt_stall),
      .ev_valid            (ev_valid),
      .ev_ready            (ev_ready),
      .ev_data             (ev_data),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_data            (out_data),
      .period_events       (period_events),
      .period_events_valid (period_events_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0]    rct;   // rst, cmd_valid, tt_valid
      logic [NB-1:0] e;
      logic          o;
      logic [1:0]    xct;   // expected cmd_ready, tt_ready
      logic [NB-1:0] xe;
   } vec_t;

   vec_t          tbl[$];
   logic [127:0]  sb[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            cmd_seq  = 0;
   int            tt_seq   = 0;
   int            ev_seq[NB];
   logic          m_ov  = 1'b0;
   logic          m_pev = 1'b0;
   logic [15:0]   m_cnt = '0;
   logic [15:0]   m_pe  = '0;

   function automatic vec_t mkv(input logic [2:0] rct, input logic [NB-1:0] e, input logic o,
                                input logic [1:0] xct, input logic [NB-1:0] xe);
      vec_t v;
      v.rct = rct; v.e = e; v.o = o; v.xct = xct; v.xe = xe;
      return v;
   endfunction

   function automatic void add(input logic [2:0] rct, input logic [NB-1:0] e, input logic o,
                               input logic [1:0] xct, input logic [NB-1:0] xe);
      tbl.push_back(mkv(rct, e, o, xct, xe));
   endfunction

   function automatic logic [127:0] mk(input logic [3:0] src, input logic [3:0] blk, input int seq);
      return {src, blk, 56'h0, 32'(seq * 32'h9E3779B9), 32'(seq)};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input vec_t v);
      rst       = v.rct[2];
      cmd_valid = v.rct[1];
      tt_valid  = v.rct[0];
      ev_valid  = v.e;
      out_ready = v.o;
      cmd_data  = mk(4'hC, 4'h0, cmd_seq);
      tt_data   = mk(4'hA, 4'h0, tt_seq);
      for (int i = 0; i < NB; i++) ev_data[128*i +: 128] = mk(4'hE, 4'(i), ev_seq[i]);
      @(negedge clk);
      check("cmd_ready", cmd_ready, v.xct[1]);
      check("tt_ready", tt_ready, v.xct[0]);
      check("ev_ready", ev_ready, v.xe);
      check("tt_stall", tt_stall, v.rct[2] | v.rct[1]);
      check("out_valid", out_valid, m_ov);
      check("period_events", period_events, m_pe);
      check("period_events_valid", period_events_valid, m_pev);
      if (m_ov) begin
         if (sb.size() == 0) check("scoreboard_empty", 1, 0);
         else check("out_data", out_data, sb[0]);
      end
      m_pev = 1'b0;
      if (v.rct[2]) begin
         sb.delete();
         m_cnt = '0;
         m_pe  = '0;
      end else begin
         if (m_ov && v.o && sb.size() != 0) void'(sb.pop_front());
         if (v.xct[1]) begin
            sb.push_back(cmd_data);
            cmd_seq++;
         end
         if (v.xct[0]) begin
            sb.push_back(tt_data);
            tt_seq++;
            m_pe  = m_cnt;
            m_pev = 1'b1;
            m_cnt = '0;
         end
         for (int i = 0; i < NB; i++) begin
            if (v.xe[i]) begin
               sb.push_back(ev_data[128*i +: 128]);
               ev_seq[i]++;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
         end
      end
      m_ov = (sb.size() != 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NB; i++) ev_seq[i] = 0;
      rst = 1'b1; cmd_valid = 1'b0; tt_valid = 1'b0; ev_valid = '0; out_ready = 1'b0;
      cmd_data = '0; tt_data = '0; ev_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_data", out_data, 128'h0);
      check("rst_out_valid", out_valid, 1'b0);

      // reset cycles: no ready even with everything valid
      add(3'b100, 4'b0000, 1'b0, 2'b00, 4'b0000);
      add(3'b111, 4'b1111, 1'b1, 2'b00, 4'b0000);
      // round-robin over all blocks, twice
      for (int k = 0; k < 8; k++) add(3'b000, 4'b1111, 1'b1, 2'b00, 4'(1 << (k % 4)));
      // tag beats a same-cycle event, block 1 follows
      add(3'b001, 4'b0010, 1'b1, 2'b01, 4'b0000);
      add(3'b000, 4'b0010, 1'b1, 2'b00, 4'b0010);
      add(3'b000, 4'b0000, 1'b1, 2'b00, 4'b0000);
      // commands hold off the tag for three cycles
      for (int k = 0; k < 3; k++) add(3'b011, 4'b0000, 1'b1, 2'b10, 4'b0000);
      add(3'b001, 4'b0000, 1'b1, 2'b01, 4'b0000);
      add(3'b000, 4'b0000, 1'b1, 2'b00, 4'b0000);
      add(3'b000, 4'b0000, 1'b1, 2'b00, 4'b0000);
      // backpressure with all sources valid
      add(3'b000, 4'b0100, 1'b1, 2'b00, 4'b0100);
      for (int k = 0; k < 5; k++) add(3'b011, 4'b1111, 1'b0, 2'b00, 4'b0000);
      add(3'b011, 4'b1111, 1'b1, 2'b10, 4'b0000);
      add(3'b000, 4'b1111, 1'b1, 2'b00, 4'b1000);
      add(3'b000, 4'b1111, 1'b1, 2'b00, 4'b0001);
      add(3'b000, 4'b0000, 1'b0, 2'b00, 4'b0000);
      add(3'b000, 4'b0000, 1'b1, 2'b00, 4'b0000);
      add(3'b000, 4'b0000, 1'b1, 2'b00, 4'b0000);

      for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

      // counter saturation across a long period, then a short period
      step(mkv(3'b001, 4'b0000, 1'b1, 2'b01, 4'b0000));
      for (int k = 0; k < 70000; k++) step(mkv(3'b000, 4'b0001, 1'b1, 2'b00, 4'b0001));
      step(mkv(3'b001, 4'b0000, 1'b1, 2'b01, 4'b0000));
      check("pe_saturated", period_events, 16'hFFFF);
      check("pe_valid_sat", period_events_valid, 1'b1);
      for (int k = 0; k < 3; k++) step(mkv(3'b000, 4'b0001, 1'b1, 2'b00, 4'b0001));
      step(mkv(3'b001, 4'b0000, 1'b1, 2'b01, 4'b0000));
      check("pe_three", period_events, 16'd3);
      step(mkv(3'b000, 4'b0000, 1'b1, 2'b00, 4'b0000));
      check("pe_valid_one_cycle", period_events_valid, 1'b0);

      // reset while a word is stalled in the output register
      step(mkv(3'b000, 4'b0010, 1'b1, 2'b00, 4'b0010));
      step(mkv(3'b111, 4'b1111, 1'b0, 2'b00, 4'b0000));
      check("rst_discard_valid", out_valid, 1'b0);
      step(mkv(3'b000, 4'b1111, 1'b1, 2'b00, 4'b0001));
      step(mkv(3'b000, 4'b0000, 1'b1, 2'b00, 4'b0000));
      step(mkv(3'b000, 4'b0000, 1'b1, 2'b00, 4'b0000));
      check("final_scoreboard_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
